// File: rtl/axis_stream_arbiter_if.sv
// rtl/axis_stream_arbiter_if.sv - stream bundle between peripheral sources, the arbiter and the capture sink
interface axis_stream_arbiter_if #(
  parameter int NUM_CH          = 4,
  parameter int AXIS_DATA_WIDTH = 8
);
  logic [NUM_CH-1:0]                 s_axis_tvalid_i;
  logic [NUM_CH*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i;
  logic [NUM_CH-1:0]                 s_axis_tflag_i;
  logic [NUM_CH-1:0]                 s_axis_tready_o;
  logic                              m_axis_tvalid_o;
  logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata_o;
  logic                              m_axis_tflag_o;
  logic                              m_axis_tready_i;

  // master: the arbiter side, driving the merged stream and per-source ready
  modport master (
    input  s_axis_tvalid_i, s_axis_tdata_i, s_axis_tflag_i, m_axis_tready_i,
    output s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tflag_o
  );

  modport slave (
    output s_axis_tvalid_i, s_axis_tdata_i, s_axis_tflag_i, m_axis_tready_i,
    input  s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, m_axis_tflag_o
  );
endinterface

// File: rtl/axis_stream_arbiter.sv
// rtl/axis_stream_arbiter.sv - round-robin stream arbiter with CPU control/status window
// Define AXIS_ARB_PKT_LOCK_EN to hold the grant for a whole packet; otherwise arbitration is per beat.
module axis_stream_arbiter #(
  parameter logic [7:0] SOC_SEGMENT     = 8'he4,
  parameter logic [7:0] SOC_CLASS       = 8'haa,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         NUM_CH          = 4
) (
  input  logic                 axis_aclk_i,
  input  logic                 axis_aresetn_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  input  logic                 data_w_i,
  output logic [31:0]          data_o,
  output logic                 data_access_o,
  axis_stream_arbiter_if.master axis
);
  localparam int         W       = AXIS_DATA_WIDTH;
  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  typedef enum logic {ARB, GRANT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              m_valid_q, m_valid_d;
  logic              m_flag_q, m_flag_d;
  logic [W-1:0]      m_data_q, m_data_d;
  logic [31:0]       data_q, data_d;

  logic [W-1:0]      ch_data [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [1:0]        pick;
  logic [2:0]        cand;
  logic              out_free;
  logic              accept;
  logic              release_grant;
  logic [2:0]        reg_sel;
  logic [3:0]        raw_valid;
  logic              unused_bits;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_data[c] = axis.s_axis_tdata_i[c*W +: W];
  end

  always_comb begin
    raw_valid = '0;
    raw_valid[NUM_CH-1:0] = axis.s_axis_tvalid_i;
  end

  assign eligible = axis.s_axis_tvalid_i & mask_q;
  assign out_free = !m_valid_q || axis.m_axis_tready_i;
  assign accept   = (state_q == GRANT) && axis.s_axis_tvalid_i[grant_q] && out_free;

`ifdef AXIS_ARB_PKT_LOCK_EN
  assign release_grant = accept && axis.s_axis_tflag_i[grant_q];
`else
  assign release_grant = accept;
`endif

  // Search starts one past the last winner so every source gets its turn.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = 3'(last_q) + 3'(i);
      if (cand >= 3'(NUM_CH)) cand = cand - 3'(NUM_CH);
      if (!found && eligible[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    last_d               = last_q;
    axis.s_axis_tready_o = '0;
    case (state_q)
      ARB: begin
        if (found) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        axis.s_axis_tready_o[grant_q] = out_free;
        if (release_grant) begin
          last_d  = grant_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_flag_d  = m_flag_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = ch_data[grant_q];
      m_flag_d  = axis.s_axis_tflag_i[grant_q];
    end else if (axis.m_axis_tready_i) begin
      m_valid_d = 1'b0;
    end
  end

  assign data_access_o = (addr_i[31:24] == SOC_SEGMENT) && (addr_i[23:16] == SOC_CLASS);
  assign reg_sel       = addr_i[6:4];
  assign unused_bits   = ^{addr_i[15:7], addr_i[3:0], data_i[31:NUM_CH]};

  // Read data comes from the pre-write mask, so a write cycle returns the old CTRL value.
  always_comb begin
    mask_d = mask_q;
    data_d = data_q;
    if (data_access_o) begin
      case (reg_sel)
        3'b100:  data_d = 32'(mask_q);
        3'b101:  data_d = {20'd0, raw_valid, 4'd0, m_valid_q, state_q == GRANT, grant_q};
        default: data_d = '0;
      endcase
      if (data_w_i && reg_sel == 3'b100) mask_d = data_i[NUM_CH-1:0];
    end
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      state_q   <= ARB;
      grant_q   <= '0;
      last_q    <= LAST_CH;
      mask_q    <= '1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_flag_q  <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      mask_q    <= mask_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_flag_q  <= m_flag_d;
      data_q    <= data_d;
    end
  end

  assign axis.m_axis_tvalid_o = m_valid_q;
  assign axis.m_axis_tdata_o  = m_data_q;
  assign axis.m_axis_tflag_o  = m_flag_q;
  assign data_o               = data_q;
endmodule

// File: tb/tb_axis_stream_arbiter.sv
// tb/tb_axis_stream_arbiter.sv - register vector table plus scoreboarded stream scenarios for axis_stream_arbiter
module tb_axis_stream_arbiter;
  localparam int NUM_CH = 4;
  localparam int W      = 8;
`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam bit PKT_LOCK = 1'b1;
`else
  localparam bit PKT_LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr, wdata, rdata;
  logic        we, access;

  always #5 clk = ~clk;

  axis_stream_arbiter_if #(.NUM_CH(NUM_CH), .AXIS_DATA_WIDTH(W)) ifc ();

  axis_stream_arbiter #(
    .SOC_SEGMENT(8'he4), .SOC_CLASS(8'haa), .AXIS_DATA_WIDTH(W), .NUM_CH(NUM_CH)
  ) dut (
    .axis_aclk_i(clk), .axis_aresetn_i(rst_n),
    .addr_i(addr), .data_i(wdata), .data_w_i(we),
    .data_o(rdata), .data_access_o(access),
    .axis(ifc)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        acc;
    logic [31:0] rd;
  } reg_vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  logic [8:0]  src_q [NUM_CH][$];
  logic [8:0]  exp_q [$];
  int          out_cyc [$];
  logic        ds_ready = 1'b1;
  logic [NUM_CH-1:0] smp_tready;
  logic        smp_mvalid, smp_mflag;
  logic [7:0]  smp_mdata;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < NUM_CH; c++) begin
      ifc.s_axis_tvalid_i[c]       = src_q[c].size() != 0;
      ifc.s_axis_tdata_i[c*W +: W] = (src_q[c].size() != 0) ? src_q[c][0][7:0] : 8'h00;
      ifc.s_axis_tflag_i[c]        = (src_q[c].size() != 0) ? src_q[c][0][8] : 1'b0;
    end
    ifc.m_axis_tready_i = ds_ready;
  endtask

  // Samples at the falling edge (handshakes that the next rising edge will take), then updates sources.
  task automatic tick();
    logic [NUM_CH-1:0] hs;
    @(negedge clk);
    cyc++;
    smp_tready = ifc.s_axis_tready_o;
    smp_mvalid = ifc.m_axis_tvalid_o;
    smp_mdata  = ifc.m_axis_tdata_o;
    smp_mflag  = ifc.m_axis_tflag_o;
    hs = ifc.s_axis_tvalid_i & ifc.s_axis_tready_o;
    chk_eq("tready_onehot", 32'($countones(smp_tready) <= 1), 32'd1);
    if (smp_mvalid && ds_ready) begin
      out_cnt++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no output", {smp_mflag, smp_mdata});
      end else begin
        chk_eq("out_beat", {23'd0, smp_mflag, smp_mdata}, {23'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++)
      if (hs[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
    drive_src();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk_eq(name, exp_q.size(), 0);
  endtask

  task automatic reg_op(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic exp_acc, input logic [31:0] exp_rd);
    addr = a; wdata = d; we = w;
    #1;
    chk_eq({name, "_access"}, 32'(access), 32'(exp_acc));
    tick();
    chk_eq({name, "_rdata"}, rdata, exp_rd);
    addr = '0; wdata = '0; we = 1'b0;
  endtask

  task automatic push_beat(input int ch, input logic flag, input logic [7:0] d);
    src_q[ch].push_back({flag, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reg_vec_t   rv [12];
    logic [7:0] ord [6];
    int         gap [6];
    int         start, n;

    rv[0]  = '{32'hE4AA_0050, 32'h0,  1'b0, 1'b1, 32'h0};
    rv[1]  = '{32'hE4AA_0040, 32'h0,  1'b0, 1'b1, 32'hF};
    rv[2]  = '{32'hE4AB_0040, 32'h0,  1'b0, 1'b0, 32'hF};
    rv[3]  = '{32'hE5AA_0040, 32'h0,  1'b0, 1'b0, 32'hF};
    rv[4]  = '{32'hE4AA_0060, 32'h0,  1'b1, 1'b1, 32'h0};
    rv[5]  = '{32'hE4AA_0040, 32'h0,  1'b0, 1'b1, 32'hF};
    rv[6]  = '{32'hE4AA_0040, 32'h3,  1'b1, 1'b1, 32'hF};
    rv[7]  = '{32'hE4AA_0040, 32'h0,  1'b0, 1'b1, 32'h3};
    rv[8]  = '{32'hE4AA_0040, 32'hFF, 1'b1, 1'b1, 32'h3};
    rv[9]  = '{32'hE4AA_0040, 32'h0,  1'b0, 1'b1, 32'hF};
    rv[10] = '{32'hE4AA_0000, 32'h0,  1'b0, 1'b1, 32'h0};
    rv[11] = '{32'hE4AA_0145, 32'h0,  1'b0, 1'b1, 32'hF};

    addr = '0; wdata = '0; we = 1'b0;
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_tready", 32'(ifc.s_axis_tready_o), 0);
    chk_eq("rst_mvalid", 32'(ifc.m_axis_tvalid_o), 0);
    chk_eq("rst_mdata",  32'(ifc.m_axis_tdata_o), 0);
    chk_eq("rst_mflag",  32'(ifc.m_axis_tflag_o), 0);
    chk_eq("rst_data_o", rdata, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      reg_op($sformatf("regvec%0d", i), rv[i].addr, rv[i].wdata, rv[i].we, rv[i].acc, rv[i].rd);

    // single beat from ch0: 1 ARB cycle, accept, then output
    push_beat(0, 1'b1, 8'h41);
    exp_q.push_back({1'b1, 8'h41});
    drive_src();
    tick(); chk_eq("s1_arb_no_ready", 32'(smp_tready), 0);
    tick(); chk_eq("s1_grant_ready", 32'(smp_tready), 32'b0001);
    tick(); chk_eq("s1_out_valid", 32'(smp_mvalid), 1);
    chk_eq("s1_out_data", 32'(smp_mdata), 32'h41);
    chk_eq("s1_out_flag", 32'(smp_mflag), 1);
    chk_eq("s1_drained", exp_q.size(), 0);
    reg_op("s1_status", 32'hE4AA_0050, 0, 1'b0, 1'b1, 32'h0);

    // two simultaneous 3-beat packets
    if (PKT_LOCK) begin
      ord = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
      gap = '{0, 1, 1, 2, 1, 1};
    end else begin
      ord = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
      gap = '{0, 2, 2, 2, 2, 2};
    end
    for (int b = 0; b < 3; b++) begin
      push_beat(1, b == 2, 8'(8'h10 + b));
      push_beat(2, b == 2, 8'(8'h20 + b));
    end
    for (int i = 0; i < 6; i++) exp_q.push_back({ord[i][3:0] == 4'h2, ord[i]});
    out_cyc.delete();
    drive_src();
    wait_drain(40, "s2_drain");
    chk_eq("s2_nbeats", out_cyc.size(), 6);
    for (int i = 1; i < out_cyc.size() && i < 6; i++)
      chk_eq($sformatf("s2_gap%0d", i), out_cyc[i] - out_cyc[i-1], gap[i]);

    // all four channels with single-beat packets rotate from the last winner (ch2)
    for (int c = 0; c < NUM_CH; c++) begin
      push_beat(c, 1'b1, 8'(8'h30 + c));
      push_beat(c, 1'b1, 8'(8'h34 + c));
    end
    exp_q.push_back({1'b1, 8'h33});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 8'(8'h30 + k)});
    exp_q.push_back({1'b1, 8'h37});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 8'(8'h34 + k)});
    out_cyc.delete();
    drive_src();
    wait_drain(40, "s3_drain");
    chk_eq("s3_nbeats", out_cyc.size(), 8);
    for (int i = 1; i < out_cyc.size(); i++)
      chk_eq($sformatf("s3_gap%0d", i), out_cyc[i] - out_cyc[i-1], 2);

    // masked channels are never granted; re-enable takes effect from the following ARB
    reg_op("s4_wr_mask9", 32'hE4AA_0040, 32'h9, 1'b1, 1'b1, 32'hF);
    push_beat(1, 1'b1, 8'h51);
    push_beat(2, 1'b1, 8'h52);
    drive_src();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_eq($sformatf("s4_masked_ready%0d", k), 32'(smp_tready), 0);
    end
    reg_op("s4_status", 32'hE4AA_0050, 0, 1'b0, 1'b1, 32'h602);
    exp_q.push_back({1'b1, 8'h51});
    exp_q.push_back({1'b1, 8'h52});
    reg_op("s4_wr_maskF", 32'hE4AA_0040, 32'hF, 1'b1, 1'b1, 32'h9);
    tick(); chk_eq("s4_old_mask_no_ready", 32'(smp_tready), 0);
    tick(); chk_eq("s4_ch1_first", 32'(smp_tready), 32'b0010);
    wait_drain(20, "s4_drain");

    // downstream stall mid-packet
    for (int b = 0; b < 4; b++) push_beat(0, b == 3, 8'(8'h60 + b));
    for (int b = 0; b < 4; b++) exp_q.push_back({b == 3, 8'(8'h60 + b)});
    drive_src();
    start = out_cnt;
    n = 0;
    while (out_cnt == start && n < 20) begin
      tick();
      n++;
    end
    chk_eq("s5_first_out", out_cnt - start, 1);
    ds_ready = 1'b0;
    drive_src();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 2) begin
        chk_eq($sformatf("s5_hold_valid%0d", k), 32'(smp_mvalid), 1);
        chk_eq($sformatf("s5_hold_data%0d", k), 32'(smp_mdata), 32'h61);
        chk_eq($sformatf("s5_hold_ready%0d", k), 32'(smp_tready), 0);
      end
    end
    ds_ready = 1'b1;
    drive_src();
    wait_drain(20, "s5_drain");

    // reset in the middle of a packet
    for (int b = 0; b < 4; b++) push_beat(1, b == 3, 8'(8'h70 + b));
    for (int b = 0; b < 4; b++) exp_q.push_back({b == 3, 8'(8'h70 + b)});
    drive_src();
    start = out_cnt;
    n = 0;
    while (out_cnt - start < 2 && n < 20) begin
      tick();
      n++;
    end
    chk_eq("s6_two_beats_out", out_cnt - start, 2);
    rst_n = 1'b0;
    #1;
    chk_eq("s6_rst_tready", 32'(ifc.s_axis_tready_o), 0);
    chk_eq("s6_rst_mvalid", 32'(ifc.m_axis_tvalid_o), 0);
    chk_eq("s6_rst_mdata",  32'(ifc.m_axis_tdata_o), 0);
    chk_eq("s6_rst_mflag",  32'(ifc.m_axis_tflag_o), 0);
    chk_eq("s6_rst_data_o", rdata, 0);
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    exp_q.delete();
    drive_src();
    repeat (2) tick();
    rst_n = 1'b1;
    push_beat(3, 1'b1, 8'h83);
    push_beat(0, 1'b1, 8'h80);
    exp_q.push_back({1'b1, 8'h80});
    exp_q.push_back({1'b1, 8'h83});
    drive_src();
    wait_drain(20, "s6_drain");

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
